rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Reorder buffer for the out-of-order core; it drives the register file's rename and writeback interface from the producer side.
- On dispatch it allocates an in-order entry and announces the destination rename (rd_in_*) to the register file.
- It collects results from the CDB and retires the head entry in order, driving rd_out_* to the register file.
- Mispredicted branches are resolved at commit by a one-cycle flush; the block also answers reservation-station operand queries for in-flight results.

Parameters:
- DEPTH, 16, number of entries; must equal 2^TAG_W.
- TAG_W, 4, entry tag width; matches the register-file rename field.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = hold all state, all pulse outputs low
- issue_valid  in  1  dispatch request this cycle
- issue_rd  in  5  destination register; 0 = none
- issue_is_br  in  1  entry is a branch
- issue_is_st  in  1  entry is a store
- issue_ready  out  1  entry can be allocated this cycle
- issue_tag  out  TAG_W  tag given to the dispatched entry (current tail)
- rd_in_flag  out  1  rename pulse to the register file
- rd_in_a  out  5  renamed register
- rd_in_rob  out  TAG_W  new owner tag
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing entry
- cdb_val  in  32  result value
- cdb_mispred  in  1  branch resolved as mispredicted
- cdb_target  in  32  correct PC for a mispredicted branch
- q1_tag, q2_tag  in  TAG_W  operand query tags
- q1_ready, q2_ready  out  1  queried entry has a result
- q1_val, q2_val  out  32  queried entry's result
- rd_out_flag  out  1  commit-write pulse
- rd_out_a  out  5  committed register
- rd_out_val  out  32  committed value
- rd_out_rob  out  TAG_W  committed tag
- st_commit  out  1  head store retired; LSB may perform the write
- st_commit_tag  out  TAG_W  tag of the retired store
- flush  out  1  pipeline flush pulse
- flush_pc  out  32  redirect PC

Behaviour:
- Storage: circular buffer with head, tail and count (TAG_W+1 bits). Each entry holds busy, done, rd, is_br, is_st, mispred, val, target.
- Reset: head=tail=count=0; all busy/done cleared. All pulse outputs 0, flush_pc=0, and issue_ready=1 from the first cycle after reset.
- issue_ready = (count != DEPTH) and not flush. Full blocks issue even if a commit occurs in the same cycle.
- Dispatch (issue_valid & issue_ready & rdy): write the entry at tail (busy=1, done=0), tail+1 mod DEPTH, issue_tag = pre-increment tail.
  - If issue_rd != 0: rd_in_flag=1, rd_in_a=issue_rd, rd_in_rob=tail in the same cycle.
  - Stores and branches with rd=0 never rename.
- CDB: if cdb_valid and entry cdb_tag is busy, set done=1 and latch val, mispred and target. A CDB result for a non-busy tag is ignored.
- Commit: the head entry retires when busy & done & rdy. At most one retire per cycle.
  - rd != 0: rd_out_flag pulse with rd, val and head tag.
  - is_st: st_commit pulse with the head tag.
  - is_br & mispred: flush=1, flush_pc=target for one cycle. Next cycle: head=tail=count=0, all busy cleared, and the dispatch and CDB inputs of the flush cycle are discarded.
- Register-file exclusivity: the register file drops rd_out_* when rd_in_flag is high in the same cycle. Therefore a head entry with rd != 0 does not retire in a cycle where a renaming dispatch fires; it retires on the next cycle. Entries with rd = 0 retire regardless.
- The count update handles dispatch and retire in the same cycle (net 0).
- Query: q*_ready = busy[q*_tag] & done[q*_tag]; q*_val = val[q*_tag]. This path is combinational.
- rdy low: no allocate, no retire, no CDB capture, and all pulses low.
- rst has priority over everything, including an in-progress flush.

Optional Feature:
- Macro ROB_BYPASS_EN.
- Defined: the query outputs also forward the live CDB. If cdb_valid and cdb_tag == q*_tag, then q*_ready=1 and q*_val=cdb_val in the same cycle.
- Not defined: the queried result becomes visible the cycle after CDB capture.

Test Plan:
- Reset then dispatch rd=5 -> rd_in_flag=1, rd_in_a=5, rd_in_rob=0, issue_tag=0. Then CDB tag0 val 0x1234 -> next cycle rd_out_flag=1, rd_out_a=5, rd_out_val=0x1234, rd_out_rob=0.
- 16 dispatches with no CDB -> issue_ready=0 and a 17th issue_valid is ignored. Complete tag0 -> it retires and issue_ready=1 the following cycle. Further dispatches wrap the tail to tag 0.
- Complete tags 2, 1, 0 in reverse order -> commits emerge as tags 0, 1, 2 on consecutive cycles.
- Head done with rd=3 while a dispatch with rd=7 fires -> rd_in_flag only that cycle; rd_out for rd=3 on the next cycle.
- Branch at tag1 with cdb_mispred=1, target 0x100, and tag2 busy -> at commit flush=1 and flush_pc=0x100. Next cycle count=0 and issue_tag=0; a CDB result for tag2 is then ignored.
- Query q1_tag=4 while the CDB broadcasts tag4 = 0xAA -> q1_ready=1, q1_val=0xAA that cycle if ROB_BYPASS_EN is defined, otherwise the following cycle.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with dispatch renaming, CDB capture, commit and commit-time flush.
// Optional: define ROB_BYPASS_EN to forward the live CDB onto the operand query outputs.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_is_br,
  input  logic             issue_is_st,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rd_in_flag,
  output logic [4:0]       rd_in_a,
  output logic [TAG_W-1:0] rd_in_rob,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_mispred,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             rd_out_flag,
  output logic [4:0]       rd_out_a,
  output logic [31:0]      rd_out_val,
  output logic [TAG_W-1:0] rd_out_rob,
  output logic             st_commit,
  output logic [TAG_W-1:0] st_commit_tag,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] busy, done;

  logic [4:0]  rd_q  [DEPTH];
  logic        br_q  [DEPTH];
  logic        st_q  [DEPTH];
  logic        mis_q [DEPTH];
  logic [31:0] val_q [DEPTH];
  logic [31:0] tgt_q [DEPTH];

  logic head_live, flush_c, dispatch, rename, retire, cdb_hit;

  // A mispredicted head branch blocks issue, so it never loses its retire slot to a rename.
  assign head_live   = busy[head] & done[head] & rdy;
  assign flush_c     = head_live & br_q[head] & mis_q[head];
  assign issue_ready = (count != FULL_CNT) & ~flush_c;
  assign dispatch    = issue_valid & issue_ready & rdy;
  assign rename      = dispatch & (issue_rd != 5'd0);
  // The register file drops a commit write that collides with a rename, so defer it a cycle.
  assign retire      = head_live & ~((rd_q[head] != 5'd0) & rename);
  assign cdb_hit     = rdy & cdb_valid & busy[cdb_tag];

  assign issue_tag     = tail;
  assign rd_in_flag    = rename;
  assign rd_in_a       = issue_rd;
  assign rd_in_rob     = tail;
  assign rd_out_flag   = retire & (rd_q[head] != 5'd0);
  assign rd_out_a      = rd_q[head];
  assign rd_out_val    = val_q[head];
  assign rd_out_rob    = head;
  assign st_commit     = retire & st_q[head];
  assign st_commit_tag = head;
  assign flush         = flush_c;
  assign flush_pc      = flush_c ? tgt_q[head] : 32'd0;

`ifdef ROB_BYPASS_EN
  assign q1_ready = (cdb_valid & (cdb_tag == q1_tag)) | (busy[q1_tag] & done[q1_tag]);
  assign q2_ready = (cdb_valid & (cdb_tag == q2_tag)) | (busy[q2_tag] & done[q2_tag]);
  assign q1_val   = (cdb_valid & (cdb_tag == q1_tag)) ? cdb_val : val_q[q1_tag];
  assign q2_val   = (cdb_valid & (cdb_tag == q2_tag)) ? cdb_val : val_q[q2_tag];
`else
  assign q1_ready = busy[q1_tag] & done[q1_tag];
  assign q2_ready = busy[q2_tag] & done[q2_tag];
  assign q1_val   = val_q[q1_tag];
  assign q2_val   = val_q[q2_tag];
`endif

  // Control state: pointers, occupancy and per-entry status; a flush empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush_c) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
    end else begin
      if (cdb_hit) done[cdb_tag] <= 1'b1;
      if (retire) begin
        busy[head] <= 1'b0;
        head       <= head + TAG_W'(1);
      end
      if (dispatch) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + TAG_W'(1);
      end
      count <= count + (TAG_W+1)'(dispatch) - (TAG_W+1)'(retire);
    end
  end

  // Entry payload: only read while the entry is busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (dispatch) begin
      rd_q[tail] <= issue_rd;
      br_q[tail] <= issue_is_br;
      st_q[tail] <= issue_is_st;
    end
    if (cdb_hit) begin
      val_q[cdb_tag] <= cdb_val;
      mis_q[cdb_tag] <= cdb_mispred;
      tgt_q[cdb_tag] <= cdb_target;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: reset/dispatch/commit vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_rob_commit;

  logic        clk, rst, rdy;
  logic        issue_valid, issue_is_br, issue_is_st, issue_ready;
  logic [4:0]  issue_rd, rd_in_a, rd_out_a;
  logic [3:0]  issue_tag, rd_in_rob, cdb_tag, q1_tag, q2_tag, rd_out_rob, st_commit_tag;
  logic        rd_in_flag, cdb_valid, cdb_mispred, q1_ready, q2_ready;
  logic [31:0] cdb_val, cdb_target, q1_val, q2_val, rd_out_val, flush_pc;
  logic        rd_out_flag, st_commit, flush;

  int total = 0;
  int bad   = 0;

  rob_commit #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_is_st(issue_is_st), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a), .rd_out_val(rd_out_val),
    .rd_out_rob(rd_out_rob), .st_commit(st_commit), .st_commit_tag(st_commit_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; issue_is_br = 1'b0; issue_is_st = 1'b0;
    cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_val = 32'd0; cdb_mispred = 1'b0; cdb_target = 32'd0;
    q1_tag = 4'd0; q2_tag = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic br, input logic st);
    @(negedge clk);
    idle();
    issue_valid = 1'b1; issue_rd = rd; issue_is_br = br; issue_is_st = st;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic mis, input logic [31:0] tg);
    @(negedge clk);
    idle();
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v; cdb_mispred = mis; cdb_target = tg;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic iv; logic [4:0] ird; logic ist; logic cv; logic [3:0] ct; logic [31:0] cval;
    logic x_ir; logic [3:0] x_itag; logic x_rin; logic [4:0] x_rina;
    logic x_rout; logic [4:0] x_routa; logic [31:0] x_routv; logic [3:0] x_rob; logic x_st;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(int iv, int ird, int ist, int cv, int ct, int cval,
                              int xir, int xitag, int xrin, int xrina,
                              int xrout, int xrouta, int xroutv, int xrob, int xst);
    vec_t v;
    v.iv = iv[0]; v.ird = ird[4:0]; v.ist = ist[0]; v.cv = cv[0]; v.ct = ct[3:0];
    v.cval = 32'(cval); v.x_ir = xir[0]; v.x_itag = xitag[3:0]; v.x_rin = xrin[0];
    v.x_rina = xrina[4:0]; v.x_rout = xrout[0]; v.x_routa = xrouta[4:0];
    v.x_routv = 32'(xroutv); v.x_rob = xrob[3:0]; v.x_st = xst[0];
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] tag; logic [4:0] rd; bit br; bit st; bit dn; bit mis;
    logic [31:0] val; logic [31:0] tgt;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mtag;
  bit         e_flush, e_ir, m_disp, m_ren, m_ret, e_rout, e_st;

  function automatic void mquery(input logic [3:0] t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[i]) if (mq[i].tag == t && mq[i].dn) begin r = 1'b1; v = mq[i].val; end
`ifdef ROB_BYPASS_EN
    if (cdb_valid && cdb_tag == t) begin r = 1'b1; v = cdb_val; end
`endif
  endfunction

  task automatic model_eval();
    bit hd;
    hd      = (mq.size() > 0) && mq[0].dn;
    e_flush = rdy && hd && mq[0].br && mq[0].mis;
    e_ir    = (mq.size() != 16) && !e_flush;
    m_disp  = issue_valid && e_ir && rdy;
    m_ren   = m_disp && (issue_rd != 5'd0);
    m_ret   = rdy && hd && !(mq[0].rd != 5'd0 && m_ren);
    e_rout  = m_ret && (mq[0].rd != 5'd0);
    e_st    = m_ret && mq[0].st;
  endtask

  task automatic model_step();
    ent_t n;
    if (rst || e_flush) begin
      mq.delete();
      mtag = 4'd0;
    end else if (rdy) begin
      if (cdb_valid)
        foreach (mq[i]) if (mq[i].tag == cdb_tag) begin
          mq[i].dn = 1'b1; mq[i].val = cdb_val; mq[i].mis = cdb_mispred; mq[i].tgt = cdb_target;
        end
      if (m_ret) void'(mq.pop_front());
      if (m_disp) begin
        n.tag = mtag; n.rd = issue_rd; n.br = issue_is_br; n.st = issue_is_st;
        n.dn = 1'b0; n.mis = 1'b0; n.val = 32'd0; n.tgt = 32'd0;
        mq.push_back(n);
        mtag = mtag + 4'd1;
      end
    end
  endtask

  task automatic model_check();
    bit r; logic [31:0] v;
    chk("r_ready", 32'(issue_ready), 32'(e_ir));
    chk("r_itag", 32'(issue_tag), 32'(mtag));
    chk("r_rin", 32'(rd_in_flag), 32'(m_ren));
    if (m_ren) begin
      chk("r_rin_a", 32'(rd_in_a), 32'(issue_rd));
      chk("r_rin_rob", 32'(rd_in_rob), 32'(mtag));
    end
    chk("r_rout", 32'(rd_out_flag), 32'(e_rout));
    if (e_rout) begin
      chk("r_rout_a", 32'(rd_out_a), 32'(mq[0].rd));
      chk("r_rout_val", rd_out_val, mq[0].val);
      chk("r_rout_rob", 32'(rd_out_rob), 32'(mq[0].tag));
    end
    chk("r_st", 32'(st_commit), 32'(e_st));
    if (e_st) chk("r_st_tag", 32'(st_commit_tag), 32'(mq[0].tag));
    chk("r_flush", 32'(flush), 32'(e_flush));
    chk("r_flush_pc", flush_pc, e_flush ? mq[0].tgt : 32'd0);
    mquery(q1_tag, r, v);
    chk("r_q1_ready", 32'(q1_ready), 32'(r));
    if (r) chk("r_q1_val", q1_val, v);
    mquery(q2_tag, r, v);
    chk("r_q2_ready", 32'(q2_ready), 32'(r));
    if (r) chk("r_q2_val", q2_val, v);
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Table: reset state, rename/commit of rd=5, reverse completion, store commit.
    tbl[0]  = mk(0,0,0, 0,0,0,        1,0, 0,0, 0,0,0,0, 0);
    tbl[1]  = mk(1,5,0, 0,0,0,        1,0, 1,5, 0,0,0,0, 0);
    tbl[2]  = mk(0,0,0, 1,0,'h1234,   1,1, 0,0, 0,0,0,0, 0);
    tbl[3]  = mk(0,0,0, 0,0,0,        1,1, 0,0, 1,5,'h1234,0, 0);
    tbl[4]  = mk(1,1,0, 0,0,0,        1,1, 1,1, 0,0,0,0, 0);
    tbl[5]  = mk(1,2,0, 0,0,0,        1,2, 1,2, 0,0,0,0, 0);
    tbl[6]  = mk(1,0,1, 0,0,0,        1,3, 0,0, 0,0,0,0, 0);
    tbl[7]  = mk(0,0,0, 1,3,'h33,     1,4, 0,0, 0,0,0,0, 0);
    tbl[8]  = mk(0,0,0, 1,2,'h22,     1,4, 0,0, 0,0,0,0, 0);
    tbl[9]  = mk(0,0,0, 1,1,'h11,     1,4, 0,0, 0,0,0,0, 0);
    tbl[10] = mk(0,0,0, 0,0,0,        1,4, 0,0, 1,1,'h11,1, 0);
    tbl[11] = mk(0,0,0, 0,0,0,        1,4, 0,0, 1,2,'h22,2, 0);
    tbl[12] = mk(0,0,0, 0,0,0,        1,4, 0,0, 0,0,0,3, 1);
    tbl[13] = mk(0,0,0, 0,0,0,        1,4, 0,0, 0,0,0,0, 0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      idle();
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; issue_is_st = tbl[i].ist;
      cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_val = tbl[i].cval;
      #1;
      chk($sformatf("t%0d_ready", i), 32'(issue_ready), 32'(tbl[i].x_ir));
      chk($sformatf("t%0d_itag", i), 32'(issue_tag), 32'(tbl[i].x_itag));
      chk($sformatf("t%0d_rin", i), 32'(rd_in_flag), 32'(tbl[i].x_rin));
      if (tbl[i].x_rin) begin
        chk($sformatf("t%0d_rin_a", i), 32'(rd_in_a), 32'(tbl[i].x_rina));
        chk($sformatf("t%0d_rin_rob", i), 32'(rd_in_rob), 32'(tbl[i].x_itag));
      end
      chk($sformatf("t%0d_rout", i), 32'(rd_out_flag), 32'(tbl[i].x_rout));
      if (tbl[i].x_rout) begin
        chk($sformatf("t%0d_rout_a", i), 32'(rd_out_a), 32'(tbl[i].x_routa));
        chk($sformatf("t%0d_rout_val", i), rd_out_val, tbl[i].x_routv);
        chk($sformatf("t%0d_rout_rob", i), 32'(rd_out_rob), 32'(tbl[i].x_rob));
      end
      chk($sformatf("t%0d_st", i), 32'(st_commit), 32'(tbl[i].x_st));
      if (tbl[i].x_st) chk($sformatf("t%0d_st_tag", i), 32'(st_commit_tag), 32'(tbl[i].x_rob));
      chk($sformatf("t%0d_flush", i), 32'(flush), 32'd0);
      chk($sformatf("t%0d_flush_pc", i), flush_pc, 32'd0);
    end

    // Full buffer: 17th dispatch ignored, full blocks issue during a commit, tail wraps.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dispatch(5'(i + 1), 1'b0, 1'b0);
      #1;
      chk("full_fill_ready", 32'(issue_ready), 32'd1);
      chk("full_fill_tag", 32'(issue_tag), 32'(i));
    end
    dispatch(5'd9, 1'b0, 1'b0);
    #1;
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_17th_rin", 32'(rd_in_flag), 32'd0);
    cdb(4'd0, 32'h77, 1'b0, 32'd0);
    #1;
    chk("full_cdb_ready", 32'(issue_ready), 32'd0);
    @(negedge clk); idle(); #1;
    chk("full_commit", 32'(rd_out_flag), 32'd1);
    chk("full_commit_a", 32'(rd_out_a), 32'd1);
    chk("full_commit_val", rd_out_val, 32'h77);
    chk("full_commit_rob", 32'(rd_out_rob), 32'd0);
    chk("full_commit_ready", 32'(issue_ready), 32'd0);
    dispatch(5'd4, 1'b0, 1'b0);
    #1;
    chk("wrap_ready", 32'(issue_ready), 32'd1);
    chk("wrap_tag", 32'(issue_tag), 32'd0);
    chk("wrap_rin_rob", 32'(rd_in_rob), 32'd0);

    // Commit deferred by a same-cycle rename.
    do_reset();
    dispatch(5'd3, 1'b0, 1'b0);
    cdb(4'd0, 32'h33, 1'b0, 32'd0);
    dispatch(5'd7, 1'b0, 1'b0);
    #1;
    chk("excl_rin", 32'(rd_in_flag), 32'd1);
    chk("excl_rout_blocked", 32'(rd_out_flag), 32'd0);
    @(negedge clk); idle(); #1;
    chk("excl_rout", 32'(rd_out_flag), 32'd1);
    chk("excl_rout_a", 32'(rd_out_a), 32'd3);
    chk("excl_rout_rob", 32'(rd_out_rob), 32'd0);

    // Mispredicted branch flush: flush-cycle inputs discarded, later CDB to old tag ignored.
    do_reset();
    dispatch(5'd1, 1'b0, 1'b0);
    dispatch(5'd0, 1'b1, 1'b0);
    dispatch(5'd2, 1'b0, 1'b0);
    cdb(4'd0, 32'h10, 1'b0, 32'd0);
    cdb(4'd1, 32'h0, 1'b1, 32'h100);
    #1;
    chk("fl_pre_rout", 32'(rd_out_flag), 32'd1);
    chk("fl_pre_flush", 32'(flush), 32'd0);
    @(negedge clk); idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h99;
    #1;
    chk("fl_flush", 32'(flush), 32'd1);
    chk("fl_pc", flush_pc, 32'h100);
    chk("fl_ready", 32'(issue_ready), 32'd0);
    chk("fl_rin", 32'(rd_in_flag), 32'd0);
    @(negedge clk); idle();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h55;
    #1;
    chk("fl_after_flush", 32'(flush), 32'd0);
    chk("fl_after_pc", flush_pc, 32'd0);
    chk("fl_after_tag", 32'(issue_tag), 32'd0);
    chk("fl_after_ready", 32'(issue_ready), 32'd1);
    @(negedge clk); idle(); q1_tag = 4'd2; #1;
    chk("fl_stale_q1", 32'(q1_ready), 32'd0);
    chk("fl_stale_rout", 32'(rd_out_flag), 32'd0);

    // Operand query against a live CDB broadcast.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 1'b0, 1'b0);
    cdb(4'd4, 32'hAA, 1'b0, 32'd0);
    q1_tag = 4'd4; q2_tag = 4'd3;
    #1;
`ifdef ROB_BYPASS_EN
    chk("q_live_ready", 32'(q1_ready), 32'd1);
    chk("q_live_val", q1_val, 32'hAA);
`else
    chk("q_live_ready", 32'(q1_ready), 32'd0);
`endif
    chk("q_live_q2", 32'(q2_ready), 32'd0);
    @(negedge clk); idle(); q1_tag = 4'd4; #1;
    chk("q_next_ready", 32'(q1_ready), 32'd1);
    chk("q_next_val", q1_val, 32'hAA);

    // Randomized run against the reference model.
    do_reset();
    mq.delete();
    mtag = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      idle();
      rst         = ($urandom_range(0, 299) == 0);
      rdy         = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue_is_br = ($urandom_range(0, 4) == 0);
      issue_is_st = !issue_is_br && ($urandom_range(0, 4) == 0);
      cdb_valid   = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        cdb_tag = 4'($urandom_range(0, 15));
      cdb_val     = $urandom;
      cdb_mispred = ($urandom_range(0, 5) == 0);
      cdb_target  = $urandom;
      q1_tag      = ($urandom_range(0, 2) == 0) ? cdb_tag : 4'($urandom_range(0, 15));
      q2_tag      = 4'($urandom_range(0, 15));
      #1;
      model_eval();
      model_check();
      model_step();
    end
    @(negedge clk);
    idle();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
